seq_alu: RTL and testbench

Multi-cycle ALU stage directly downstream of the R0–R7/B0 register file. It consumes the selected register output (operand A) and B0 (operand B), executes one operation per START, and returns the result on `s_bus` with a one-hot `SR` write-enable pulse so the register file stores the result in the destination register. Single-cycle logic/arithmetic ops, iterative shifts and a 16-step shift-add multiplier share one small FSM.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/result bundle between the register file and the multi-cycle ALU stage.
// The slave side is the ALU; fsm_state exposes the controller state for observation.
interface seq_alu_if #(parameter int W = 16);
    logic         START;
    logic [2:0]   OP;
    logic [2:0]   DST;
    logic [W-1:0] a_q;
    logic [W-1:0] b0_q;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] s_bus;
    logic [7:0]   SR;
    logic         FLAG_Z;
    logic         FLAG_N;
    logic         FLAG_C;
    logic [1:0]   fsm_state;

    // START is a request, not a valid/ready handshake: it is sampled only
    // while the stage is idle (BUSY=0). A START seen while BUSY=1 is dropped,
    // never queued. DONE pulses for exactly one cycle in the WB state.
    modport master (
        output START, OP, DST, a_q, b0_q,
        input  BUSY, DONE, s_bus, SR, FLAG_Z, FLAG_N, FLAG_C, fsm_state
    );
    modport slave (
        input  START, OP, DST, a_q, b0_q,
        output BUSY, DONE, s_bus, SR, FLAG_Z, FLAG_N, FLAG_C, fsm_state
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU stage: single-cycle logic/arith ops, iterative shifts and a
// shift-add multiplier, writing back through s_bus with a one-hot SR strobe.
module seq_alu #(
    parameter int W = 16
) (
    input  logic     CLK,
    input  logic     CLR,
    seq_alu_if.slave bus
);
    localparam int CW = $clog2(W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]     state;
    logic [2:0]     op_r;
    logic [2:0]     dst_r;
    logic [W-1:0]   a_r;      // operand A, doubles as the shift working value
    logic [W-1:0]   b_r;      // operand B, shifted right as the multiplier
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           sh_c;
    logic [W-1:0]   s_bus_r;
    logic           z_r, n_r, c_r;

    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   fin_res;
    logic           fin_c;
    logic           to_wb;

    // Result and carry that would be written if this RUN cycle is the last one.
    always_comb begin
        acc_sum = acc + (b_r[0] ? mcand : '0);
        fin_res = '0;
        fin_c   = 1'b0;
        to_wb   = 1'b1;
        case (op_r)
            OP_ADD: {fin_c, fin_res} = {1'b0, a_r} + {1'b0, b_r};
            OP_SUB: {fin_c, fin_res} = {1'b0, a_r} - {1'b0, b_r};
            OP_AND: fin_res = a_r & b_r;
            OP_OR:  fin_res = a_r | b_r;
            OP_XOR: fin_res = a_r ^ b_r;
            OP_SHL, OP_SHR: begin
                to_wb   = (cnt == '0);
                fin_res = a_r;
                fin_c   = sh_c;
            end
            OP_MUL: begin
                to_wb   = (cnt == '0);
                fin_res = acc_sum[W-1:0];
                fin_c   = |acc_sum[2*W-1:W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            op_r    <= '0;
            dst_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            sh_c    <= 1'b0;
            s_bus_r <= '0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
            c_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        op_r  <= bus.OP;
                        dst_r <= bus.DST;
                        a_r   <= bus.a_q;
                        b_r   <= bus.b0_q;
                        mcand <= {{W{1'b0}}, bus.a_q};
                        acc   <= '0;
                        sh_c  <= 1'b0;
                        cnt   <= (bus.OP == OP_MUL) ? CW'(W - 1) : bus.b0_q[CW-1:0];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (to_wb) begin
                        s_bus_r <= fin_res;
                        z_r     <= (fin_res == '0);
                        n_r     <= fin_res[W-1];
                        c_r     <= fin_c;
                        state   <= WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                        case (op_r)
                            OP_SHL: begin
                                a_r  <= a_r << 1;
                                sh_c <= a_r[W-1];
                            end
                            OP_SHR: begin
                                a_r  <= a_r >> 1;
                                sh_c <= a_r[0];
                            end
                            default: begin
                                acc   <= acc_sum;
                                mcand <= mcand << 1;
                                b_r   <= b_r >> 1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUSY      = (state != IDLE);
    assign bus.DONE      = (state == WB);
    assign bus.SR        = (state == WB) ? (8'b1 << dst_r) : 8'b0;
    assign bus.s_bus     = s_bus_r;
    assign bus.FLAG_Z    = z_r;
    assign bus.FLAG_N    = n_r;
    assign bus.FLAG_C    = c_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: each task drives one scenario and checks the
// write-back bus, SR strobe, flags and latency against hand-computed values.
module tb_seq_alu;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    seq_alu_if #(.W(16)) bus ();

    seq_alu #(.W(16)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one sampling edge, then scramble the
    // operand inputs so the DUT must rely on its latched copies.
    task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.DST   = dst;
        bus.a_q   = a;
        bus.b0_q  = b;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.OP    = 3'($urandom_range(0, 7));
        bus.DST   = 3'($urandom_range(0, 7));
        bus.a_q   = 16'($urandom);
        bus.b0_q  = 16'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({bus.BUSY, bus.DONE} !== 2'b00) $display("FAIL reset_busy_done: got %b required 00", {bus.BUSY, bus.DONE}); else n_pass++;
        n_checks++; if (bus.SR !== 8'h00) $display("FAIL reset_sr: got %h required 00", bus.SR); else n_pass++;
        n_checks++; if (bus.s_bus !== 16'h0000) $display("FAIL reset_s_bus: got %h required 0000", bus.s_bus); else n_pass++;
        n_checks++; if ({bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        n_checks++; if (bus.fsm_state !== 2'd0) $display("FAIL reset_state: got %0d required 0", bus.fsm_state); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        issue(OP_ADD, 3'd3, 16'h7FFF, 16'h0001);
        n_checks++; if (bus.BUSY !== 1'b1) $display("FAIL add_busy_run: got %b required 1", bus.BUSY); else n_pass++;
        wait_done(lat);
        n_checks++; if (lat !== 1) $display("FAIL add_latency: got %0d required 1", lat); else n_pass++;
        n_checks++; if (bus.BUSY !== 1'b1) $display("FAIL add_busy_wb: got %b required 1", bus.BUSY); else n_pass++;
        n_checks++; if (bus.s_bus !== 16'h8000) $display("FAIL add_s_bus: got %h required 8000", bus.s_bus); else n_pass++;
        n_checks++; if (bus.SR !== 8'h08) $display("FAIL add_sr: got %h required 08", bus.SR); else n_pass++;
        n_checks++; if ({bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 3'b010) $display("FAIL add_flags: got ZNC=%b required 010", {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        step();
        n_checks++; if ({bus.BUSY, bus.DONE, bus.SR} !== 10'b0) $display("FAIL add_after_wb: got busy/done/sr %b required 0", {bus.BUSY, bus.DONE, bus.SR}); else n_pass++;
        n_checks++; if (bus.s_bus !== 16'h8000) $display("FAIL add_hold: got %h required 8000", bus.s_bus); else n_pass++;
    endtask

    task automatic test_sub_and();
        int lat;
        issue(OP_SUB, 3'd0, 16'h0001, 16'h0002);
        wait_done(lat);
        n_checks++; if (lat !== 1) $display("FAIL sub_latency: got %0d required 1", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.SR} !== {16'hFFFF, 8'h01}) $display("FAIL sub_result: got %h/%h required ffff/01", bus.s_bus, bus.SR); else n_pass++;
        n_checks++; if ({bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 3'b011) $display("FAIL sub_flags: got ZNC=%b required 011", {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        step();
        issue(OP_AND, 3'd6, 16'h00F0, 16'h0F00);
        wait_done(lat);
        n_checks++; if ({bus.s_bus, bus.SR} !== {16'h0000, 8'h40}) $display("FAIL and_result: got %h/%h required 0000/40", bus.s_bus, bus.SR); else n_pass++;
        n_checks++; if ({bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 3'b100) $display("FAIL and_flags: got ZNC=%b required 100", {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        step();
    endtask

    task automatic test_shift();
        int lat;
        issue(OP_SHL, 3'd2, 16'h8001, 16'h0004);
        wait_done(lat);
        n_checks++; if (lat !== 5) $display("FAIL shl4_latency: got %0d required 5", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_C} !== {16'h0010, 1'b0}) $display("FAIL shl4_result: got %h c=%b required 0010 c=0", bus.s_bus, bus.FLAG_C); else n_pass++;
        step();
        issue(OP_SHR, 3'd1, 16'h0003, 16'h0000);
        wait_done(lat);
        n_checks++; if (lat !== 1) $display("FAIL shr0_latency: got %0d required 1", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_C} !== {16'h0003, 1'b0}) $display("FAIL shr0_result: got %h c=%b required 0003 c=0", bus.s_bus, bus.FLAG_C); else n_pass++;
        step();
        issue(OP_SHR, 3'd1, 16'h8001, 16'h0001);
        wait_done(lat);
        n_checks++; if (lat !== 2) $display("FAIL shr1_latency: got %0d required 2", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_N, bus.FLAG_C} !== {16'h4000, 2'b01}) $display("FAIL shr1_result: got %h n=%b c=%b required 4000 n=0 c=1", bus.s_bus, bus.FLAG_N, bus.FLAG_C); else n_pass++;
        step();
        // Upper B bits must be ignored: 0x0013 shifts by 3.
        issue(OP_SHL, 3'd5, 16'hE000, 16'h0013);
        wait_done(lat);
        n_checks++; if (lat !== 4) $display("FAIL shl3_latency: got %0d required 4", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_Z, bus.FLAG_C, bus.SR} !== {16'h0000, 2'b11, 8'h20}) $display("FAIL shl3_result: got %h z=%b c=%b sr=%h required 0000 z=1 c=1 sr=20", bus.s_bus, bus.FLAG_Z, bus.FLAG_C, bus.SR); else n_pass++;
        step();
        issue(OP_SHL, 3'd0, 16'h0001, 16'h000F);
        wait_done(lat);
        n_checks++; if (lat !== 16) $display("FAIL shl15_latency: got %0d required 16", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_N, bus.FLAG_C} !== {16'h8000, 2'b10}) $display("FAIL shl15_result: got %h n=%b c=%b required 8000 n=1 c=0", bus.s_bus, bus.FLAG_N, bus.FLAG_C); else n_pass++;
        step();
    endtask

    task automatic test_mul();
        int lat;
        issue(OP_MUL, 3'd7, 16'h0100, 16'h0100);
        wait_done(lat);
        n_checks++; if (lat !== 16) $display("FAIL mul_ovf_latency: got %0d required 16", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.SR} !== {16'h0000, 8'h80}) $display("FAIL mul_ovf_result: got %h/%h required 0000/80", bus.s_bus, bus.SR); else n_pass++;
        n_checks++; if ({bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 3'b101) $display("FAIL mul_ovf_flags: got ZNC=%b required 101", {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        step();
        issue(OP_MUL, 3'd4, 16'h00FF, 16'h0003);
        wait_done(lat);
        n_checks++; if (lat !== 16) $display("FAIL mul_latency: got %0d required 16", lat); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== {16'h02FD, 3'b000}) $display("FAIL mul_result: got %h ZNC=%b required 02fd 000", bus.s_bus, {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        step();
        issue(OP_MUL, 3'd1, 16'hFFFF, 16'h8000);
        wait_done(lat);
        n_checks++; if ({bus.s_bus, bus.FLAG_N, bus.FLAG_C} !== {16'h8000, 2'b11}) $display("FAIL mul_bit15: got %h n=%b c=%b required 8000 n=1 c=1", bus.s_bus, bus.FLAG_N, bus.FLAG_C); else n_pass++;
        step();
    endtask

    task automatic test_busy_ignore();
        int          done_cnt = 0;
        int          done_edge = -1;
        logic [15:0] got_bus = '0;
        logic [7:0]  got_sr = '0;
        issue(OP_MUL, 3'd5, 16'h0012, 16'h0034);
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            bus.START = (e == 3);
            if (e == 3) begin
                bus.OP   = OP_ADD;
                bus.DST  = 3'd1;
                bus.a_q  = 16'h0001;
                bus.b0_q = 16'h0001;
            end
            @(posedge clk);
            #1;
            bus.START = 1'b0;
            if (bus.DONE) begin
                done_cnt++;
                done_edge = e;
                got_bus   = bus.s_bus;
                got_sr    = bus.SR;
            end
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL busy_ignore_done_count: got %0d required 1", done_cnt); else n_pass++;
        n_checks++; if (done_edge !== 16) $display("FAIL busy_ignore_done_edge: got %0d required 16", done_edge); else n_pass++;
        n_checks++; if ({got_bus, got_sr} !== {16'h03A8, 8'h20}) $display("FAIL busy_ignore_result: got %h/%h required 03a8/20", got_bus, got_sr); else n_pass++;
    endtask

    task automatic test_clr_mid_run();
        int lat;
        int bad = 0;
        issue(OP_SUB, 3'd2, 16'h0001, 16'h0002);
        wait_done(lat);
        step();
        issue(OP_MUL, 3'd4, 16'h0005, 16'h0007);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if ({bus.BUSY, bus.DONE, bus.SR} !== 10'b0) $display("FAIL clr_mid_outputs: got busy/done/sr %b required 0", {bus.BUSY, bus.DONE, bus.SR}); else n_pass++;
        n_checks++; if ({bus.s_bus, bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C} !== 19'h0) $display("FAIL clr_mid_state: got %h ZNC=%b required 0000 000", bus.s_bus, {bus.FLAG_Z, bus.FLAG_N, bus.FLAG_C}); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step();
            if (bus.DONE || bus.SR != 8'h00 || bus.BUSY) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL clr_no_late_done: got %0d active cycles required 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_in = 16'h1000;
        logic [15:0] b_in = 16'h0001;
        logic [2:0]  dst_in = 3'd1;
        logic [15:0] exp_q[$];
        logic [7:0]  exp_sr;
        logic        prev_done = 1'b0;
        int          last_edge = -2;
        int          n_done = 0;
        int          bad_gap = 0;
        int          bad_res = 0;
        int          consec = 0;
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = OP_ADD;
        bus.DST   = dst_in;
        bus.a_q   = a_in;
        bus.b0_q  = b_in;
        exp_q.push_back(a_in + b_in);
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (bus.DONE) begin
                if (prev_done) consec++;
                if (e - last_edge != 3) bad_gap++;
                last_edge = e;
                exp_sr = (n_done % 2 == 0) ? 8'h02 : 8'h04;
                if (exp_q.size() == 0 || bus.s_bus !== exp_q[0] || bus.SR !== exp_sr) bad_res++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_done++;
                dst_in    = (dst_in == 3'd1) ? 3'd2 : 3'd1;
                a_in      = a_in + 16'h1000;
                b_in      = b_in + 16'h0001;
                bus.DST   = dst_in;
                bus.a_q   = a_in;
                bus.b0_q  = b_in;
                exp_q.push_back(a_in + b_in);
            end
            prev_done = bus.DONE;
        end
        bus.START = 1'b0;
        n_checks++; if (n_done !== 4) $display("FAIL b2b_done_count: got %0d required 4", n_done); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL b2b_interval: got %0d bad gaps required 0", bad_gap); else n_pass++;
        n_checks++; if (consec !== 0) $display("FAIL b2b_consecutive_done: got %0d required 0", consec); else n_pass++;
        n_checks++; if (bad_res !== 0) $display("FAIL b2b_result_sr: got %0d bad write-backs required 0", bad_res); else n_pass++;
        repeat (3) step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        clr       = 1'b1;
        bus.START = 1'b0;
        bus.OP    = 3'd0;
        bus.DST   = 3'd0;
        bus.a_q   = 16'h0000;
        bus.b0_q  = 16'h0000;
        test_reset();
        test_add();
        test_sub_and();
        test_shift();
        test_mul();
        test_busy_ignore();
        test_clr_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
